// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: debounces the board buttons, forwards press pulses to the
// start menu, and runs the menu/serve/play/game-over flow with registered outputs.
module pong_game_ctrl #(
    parameter int DB_CYCLES    = 1_000_000,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    input  logic       frame_tick,
    input  logic       miss_l,
    input  logic       miss_r,
    input  logic       single,
    input  logic       multi,
    output logic       menu_up,
    output logic       menu_down,
    output logic       menu_enter,
    output logic [2:0] state,
    output logic       mode_multi,
    output logic       ball_run,
    output logic       ball_reset,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic [1:0] rgb_sel
);

    typedef enum logic [2:0] {
        MENU  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        OVER  = 3'd3
    } state_t;

    localparam int          FW         = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(SERVE_FRAMES - 1);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
    localparam logic [19:0] DB_LAST    = 20'(DB_CYCLES - 1);

    // Button index 0 = up, 1 = down, 2 = enter.
    logic [2:0]  raw, sync0, sync1, stable, stable_d, press;
    logic [19:0] db_cnt [3];

    assign raw   = {btn_enter, btn_down, btn_up};
    assign press = stable & ~stable_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0    <= '0;
            sync1    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync0    <= raw;
            sync1    <= sync0;
            stable_d <= stable;
            for (int i = 0; i < 3; i++) begin
                if (sync1[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 20'd1;
                end
            end
        end
    end

    state_t        state_q, state_next;
    logic [FW-1:0] frame_cnt, frame_next;
    logic          mode_next, ball_reset_next;
    logic [3:0]    score1_next, score2_next;
    logic [1:0]    winner_next, rgb_next;

    always_comb begin
        state_next      = state_q;
        mode_next       = mode_multi;
        score1_next     = score1;
        score2_next     = score2;
        winner_next     = winner;
        frame_next      = frame_cnt;
        ball_reset_next = 1'b0;
        case (state_q)
            MENU: begin
                if (single || multi) begin
                    state_next      = SERVE;
                    mode_next       = !single;
                    score1_next     = '0;
                    score2_next     = '0;
                    winner_next     = '0;
                    ball_reset_next = 1'b1;
                end
            end
            SERVE: begin
                // ball_reset is high exactly on the first SERVE cycle, so a tick there is skipped.
                if (frame_tick && !ball_reset) begin
                    if (frame_cnt == FRAME_LAST) state_next = PLAY;
                    else                         frame_next = frame_cnt + 1'b1;
                end
            end
            PLAY: begin
                if (miss_l && miss_r) begin
                    state_next      = SERVE;
                    ball_reset_next = 1'b1;
                end else if (miss_l || miss_r) begin
                    if (miss_l && score2 < WIN) score2_next = score2 + 4'd1;
                    if (miss_r && score1 < WIN) score1_next = score1 + 4'd1;
                    if (miss_l && score2_next == WIN) begin
                        state_next  = OVER;
                        winner_next = 2'd2;
                    end else if (miss_r && score1_next == WIN) begin
                        state_next  = OVER;
                        winner_next = 2'd1;
                    end else begin
                        state_next      = SERVE;
                        ball_reset_next = 1'b1;
                    end
                end
            end
            OVER: begin
                if (press[2]) state_next = MENU;
            end
            default: state_next = MENU;
        endcase
        if (state_next != SERVE) frame_next = '0;

        case (state_next)
            MENU:    rgb_next = 2'd0;
            OVER:    rgb_next = 2'd2;
            default: rgb_next = 2'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MENU;
            frame_cnt  <= '0;
            mode_multi <= 1'b0;
            ball_run   <= 1'b0;
            ball_reset <= 1'b0;
            score1     <= '0;
            score2     <= '0;
            winner     <= '0;
            rgb_sel    <= '0;
            menu_up    <= 1'b0;
            menu_down  <= 1'b0;
            menu_enter <= 1'b0;
        end else begin
            state_q    <= state_next;
            frame_cnt  <= frame_next;
            mode_multi <= mode_next;
            ball_run   <= (state_next == PLAY);
            ball_reset <= ball_reset_next;
            score1     <= score1_next;
            score2     <= score2_next;
            winner     <= winner_next;
            rgb_sel    <= rgb_next;
            menu_up    <= press[0] && (state_q == MENU);
            menu_down  <= press[1] && (state_q == MENU);
            menu_enter <= press[2] && (state_q == MENU);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a table of per-cycle game vectors checked through a
// scoreboard queue, plus hand-written button debounce and reset sequences.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0;
    logic       frame_tick = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
    logic       single = 1'b0, multi = 1'b0;
    logic       menu_up, menu_down, menu_enter;
    logic [2:0] state;
    logic       mode_multi, ball_run, ball_reset;
    logic [3:0] score1, score2;
    logic [1:0] winner, rgb_sel;

    pong_game_ctrl #(.DB_CYCLES(4), .SERVE_FRAMES(2), .WIN_SCORE(3)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
        .frame_tick(frame_tick), .miss_l(miss_l), .miss_r(miss_r),
        .single(single), .multi(multi),
        .menu_up(menu_up), .menu_down(menu_down), .menu_enter(menu_enter),
        .state(state), .mode_multi(mode_multi), .ball_run(ball_run),
        .ball_reset(ball_reset), .score1(score1), .score2(score2),
        .winner(winner), .rgb_sel(rgb_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       mm;
        logic       run;
        logic       brst;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] win;
        logic [1:0] rgb;
    } outs_t;

    // Input bits: {single, multi, frame_tick, miss_l, miss_r}
    typedef struct {
        string      name;
        logic [4:0] in;
        outs_t      exp;
    } vec_t;

    localparam logic [4:0] IDLE = 5'b00000, SGL = 5'b10000, MUL = 5'b01000, BOTH = 5'b11000;
    localparam logic [4:0] TICK = 5'b00100, ML = 5'b00010, MR = 5'b00001, MLR = 5'b00011;

    vec_t  tbl [$];
    outs_t exp_q [$];
    string name_q [$];
    int    total = 0, bad = 0;
    int    cyc = 0;
    int    up_cnt = 0, down_cnt = 0, enter_cnt = 0;
    int    up_last = -1, down_last = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (menu_up)    begin up_cnt++;   up_last = cyc;   end
        if (menu_down)  begin down_cnt++; down_last = cyc; end
        if (menu_enter) enter_cnt++;
    end

    function automatic outs_t mk(input logic [2:0] st, input logic mm, input logic run,
                                 input logic brst, input logic [3:0] s1, input logic [3:0] s2,
                                 input logic [1:0] win, input logic [1:0] rgb);
        outs_t o;
        o.st = st; o.mm = mm; o.run = run; o.brst = brst;
        o.s1 = s1; o.s2 = s2; o.win = win; o.rgb = rgb;
        return o;
    endfunction

    function automatic outs_t snap();
        return mk(state, mode_multi, ball_run, ball_reset, score1, score2, winner, rgb_sel);
    endfunction

    task automatic addRow(input string nm, input logic [4:0] in, input outs_t e);
        vec_t v;
        v.name = nm; v.in = in; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives one vector for a cycle; its expectation waits in the scoreboard until the outputs update.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        {single, multi, frame_tick, miss_l, miss_r} = v.in;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(posedge clk);
        #1;
        checkOutput(name_q.pop_front(), 32'(snap()), 32'(exp_q.pop_front()));
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int d, seen;
        vec_t v;

        addRow("menu_idle",    IDLE, mk(0,0,0,0, 0,0, 0,0));
        addRow("mode_select",  BOTH, mk(1,0,0,1, 0,0, 0,1));
        addRow("entry_tick",   TICK, mk(1,0,0,0, 0,0, 0,1));
        addRow("serve_tick1",  TICK, mk(1,0,0,0, 0,0, 0,1));
        addRow("serve_hold",   IDLE, mk(1,0,0,0, 0,0, 0,1));
        addRow("serve_tick2",  TICK, mk(2,0,1,0, 0,0, 0,1));
        addRow("score1_1",     MR,   mk(1,0,0,1, 1,0, 0,1));
        addRow("serve_miss",   MR,   mk(1,0,0,0, 1,0, 0,1));
        addRow("serve_b_t1",   TICK, mk(1,0,0,0, 1,0, 0,1));
        addRow("serve_b_t2",   TICK, mk(2,0,1,0, 1,0, 0,1));
        addRow("double_miss",  MLR,  mk(1,0,0,1, 1,0, 0,1));
        addRow("serve_c_idle", IDLE, mk(1,0,0,0, 1,0, 0,1));
        addRow("serve_c_t1",   TICK, mk(1,0,0,0, 1,0, 0,1));
        addRow("serve_c_t2",   TICK, mk(2,0,1,0, 1,0, 0,1));
        addRow("score1_2",     MR,   mk(1,0,0,1, 2,0, 0,1));
        addRow("serve_d_idle", IDLE, mk(1,0,0,0, 2,0, 0,1));
        addRow("serve_d_t1",   TICK, mk(1,0,0,0, 2,0, 0,1));
        addRow("serve_d_t2",   TICK, mk(2,0,1,0, 2,0, 0,1));
        addRow("score2_1",     ML,   mk(1,0,0,1, 2,1, 0,1));
        addRow("serve_e_idle", IDLE, mk(1,0,0,0, 2,1, 0,1));
        addRow("serve_e_t1",   TICK, mk(1,0,0,0, 2,1, 0,1));
        addRow("serve_e_t2",   TICK, mk(2,0,1,0, 2,1, 0,1));
        addRow("win_left",     MR,   mk(3,0,0,0, 3,1, 1,2));
        addRow("over_miss",    MR,   mk(3,0,0,0, 3,1, 1,2));
        addRow("over_single",  SGL,  mk(3,0,0,0, 3,1, 1,2));

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_outs", 32'(snap()), 32'(mk(0,0,0,0, 0,0, 0,0)));
        checkOutput("reset_menu", 32'({menu_up, menu_down, menu_enter}), 32'd0);

        // Bouncing up button, then a clean hold.
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1; waitNeg(2);
            btn_up = 1'b0; waitNeg(2);
        end
        btn_up = 1'b1;
        d = cyc;
        waitNeg(12);
        checkOutput("bounce_count", 32'(up_cnt), 32'd1);
        checkOutput("bounce_latency", 32'(up_last), 32'(d + 7));
        btn_up = 1'b0;
        waitNeg(12);
        checkOutput("release_no_pulse", 32'(up_cnt), 32'd1);

        foreach (tbl[i]) applyStimulus(tbl[i]);
        @(negedge clk);
        {single, multi, frame_tick, miss_l, miss_r} = IDLE;

        btn_up = 1'b1; waitNeg(12);
        btn_up = 1'b0; waitNeg(12);
        checkOutput("over_up_ignored", 32'(up_cnt), 32'd1);
        checkOutput("over_hold", 32'(snap()), 32'(mk(3,0,0,0, 3,1, 1,2)));

        btn_enter = 1'b1;
        d = cyc;
        seen = -1;
        for (int i = 0; i < 30 && seen < 0; i++) begin
            @(negedge clk);
            if (state == 3'd0) seen = cyc;
        end
        checkOutput("over_exit_cycle", 32'(seen), 32'(d + 7));
        waitNeg(3);
        checkOutput("over_enter_blocked", 32'(enter_cnt), 32'd0);
        btn_enter = 1'b0; waitNeg(12);

        btn_enter = 1'b1; waitNeg(12);
        checkOutput("menu_enter_fwd", 32'(enter_cnt), 32'd1);
        btn_enter = 1'b0; waitNeg(12);

        v.name = "multi_select"; v.in = MUL;  v.exp = mk(1,1,0,1, 0,0, 0,1); applyStimulus(v);
        v.name = "multi_idle";   v.in = IDLE; v.exp = mk(1,1,0,0, 0,0, 0,1); applyStimulus(v);
        v.name = "multi_t1";     v.in = TICK; v.exp = mk(1,1,0,0, 0,0, 0,1); applyStimulus(v);
        v.name = "multi_t2";     v.in = TICK; v.exp = mk(2,1,1,0, 0,0, 0,1); applyStimulus(v);
        v.name = "score2_play";  v.in = ML;   v.exp = mk(1,1,0,1, 0,1, 0,1); applyStimulus(v);

        @(negedge clk);
        {single, multi, frame_tick, miss_l, miss_r} = IDLE;
        reset = 1'b1;
        btn_down = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midgame_reset", 32'(snap()), 32'(mk(0,0,0,0, 0,0, 0,0)));
        checkOutput("midgame_reset_menu", 32'({menu_up, menu_down, menu_enter}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        d = cyc;
        waitNeg(12);
        checkOutput("held_down_count", 32'(down_cnt), 32'd1);
        checkOutput("held_down_latency", 32'(down_last), 32'(d + 7));
        btn_down = 1'b0;
        waitNeg(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
